// File: rtl/softmax_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_pkg
//  Description : Shared Q4.28 constants and state encoding for the softmax
//                sum accumulator and its saturating adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package softmax_pkg;

    localparam int DATA_W = 32;

    // Q4.28 fixed-point constants
    localparam logic [31:0] FXP_ONE = 32'h1000_0000;
    localparam logic [31:0] FXP_MAX = 32'hFFFF_FFFF;
    localparam logic [31:0] FXP_LSB = 32'h0000_0001;

    // Accumulator state encoding
    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] DONE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sat_add_u32.sv
`default_nettype none
// ============================================================================
//  Module      : sat_add_u32
//  Description : Combinational 32-bit unsigned saturating adder. A carry out
//                of bit 31 clamps the result to all-ones and raises ovf.
//  Ports       : a, b  - unsigned addends
//                sum   - saturated sum
//                ovf   - carry out occurred (result clamped)
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_add_u32
    import softmax_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        ovf
);

    logic [32:0] w_wide;

    assign w_wide = {1'b0, a} + {1'b0, b};
    assign ovf    = w_wide[32];
    assign sum    = w_wide[32] ? FXP_MAX : w_wide[31:0];

endmodule
`default_nettype wire

// File: rtl/softmax_sum_acc.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_sum_acc
//  Description : Accumulates N_ELEM unsigned Q4.28 exponent values into one
//                saturating sum and hands it to the ln stage over a
//                valid/ready handshake. A zero sum is replaced by 1 LSB so
//                the downstream normaliser always sees a non-zero operand.
//  Ports       : clock_i          - clock, rising edge
//                reset_n_i        - synchronous active-low reset
//                add_data_i       - exp value in (Q4.28)
//                add_data_valid_i - add_data_i valid
//                add_ready_o      - element accepted this cycle when valid
//                sum_data_o       - vector sum out (Q4.28)
//                sum_data_valid_o - sum valid, held until accepted
//                sum_ready_i      - downstream accepts sum
//                sat_o            - sum saturated in current vector
//                zero_o           - raw sum was zero, replaced by 1 LSB
//                elem_cnt_o       - elements accepted in current vector
//  Revision    : 1.0 - initial release
// ============================================================================
module softmax_sum_acc #(
    parameter int N_ELEM = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic [DATA_W-1:0] add_data_i,
    input  logic              add_data_valid_i,
    output logic              add_ready_o,
    output logic [DATA_W-1:0] sum_data_o,
    output logic              sum_data_valid_o,
    input  logic              sum_ready_i,
    output logic              sat_o,
    output logic              zero_o,
    output logic [CNT_W-1:0]  elem_cnt_o
);

    import softmax_pkg::*;

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(N_ELEM - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic              r_add_ready;
    logic [31:0]       r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_sum_data;
    logic              r_sum_valid;
    logic              r_sat;
    logic              r_zero;

    logic [31:0]       w_add_sum;
    logic              w_add_ovf;
    logic              w_accept;
    logic              w_xfer;
    logic              w_last;

    sat_add_u32 u_sat_add (
        .a   (r_acc),
        .b   (add_data_i),
        .sum (w_add_sum),
        .ovf (w_add_ovf)
    );

    assign w_accept = add_data_valid_i & r_add_ready;
    assign w_xfer   = r_sum_valid & sum_ready_i;
    assign w_last   = (r_cnt == c_last_idx);

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACC:     if (w_accept && w_last) w_state_next = DONE;
            DONE:    if (w_xfer)             w_state_next = ACC;
            default: w_state_next = ACC;
        endcase
    end

    // State register; add_ready is registered from the next state so no
    // combinational path exists from sum_ready_i to add_ready_o.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_state     <= ACC;
            r_add_ready <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_add_ready <= (w_state_next == ACC);
        end
    end

    // Datapath. Saturation is sticky: once acc is all-ones, further adds
    // either overflow again or add zero, so acc stays clamped.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum_data  <= '0;
            r_sum_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_add_sum;
            r_sat <= r_sat | w_add_ovf;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum_valid <= 1'b1;
                r_sum_data  <= (w_add_sum == '0) ? FXP_LSB : w_add_sum;
                r_zero      <= (w_add_sum == '0);
            end
        end else if (w_xfer) begin
            // sum_data keeps its last value after the handshake
            r_sum_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_zero      <= 1'b0;
        end
    end

    assign add_ready_o      = r_add_ready;
    assign sum_data_o       = r_sum_data;
    assign sum_data_valid_o = r_sum_valid;
    assign sat_o            = r_sat;
    assign zero_o           = r_zero;
    assign elem_cnt_o       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_softmax_sum_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softmax_sum_acc
//  Description : Scoreboard bench for softmax_sum_acc. Instance 0 uses
//                N_ELEM=10, instance 1 uses N_ELEM=16. Expected sums are
//                queued when a vector is issued and popped by a monitor on
//                every output transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_sum_acc;

    typedef struct packed {
        logic [31:0] sum;
        logic        sat;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] adata  [2];
    logic        avld   [2];
    logic        aready [2];
    logic [31:0] sdata  [2];
    logic        svalid [2];
    logic        sready [2];
    logic        sat    [2];
    logic        zero   [2];
    logic [4:0]  cnt    [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    softmax_sum_acc #(.N_ELEM(10), .DATA_W(32), .CNT_W(5)) u_dut10 (
        .clock_i          (clk),
        .reset_n_i        (rst_n),
        .add_data_i       (adata[0]),
        .add_data_valid_i (avld[0]),
        .add_ready_o      (aready[0]),
        .sum_data_o       (sdata[0]),
        .sum_data_valid_o (svalid[0]),
        .sum_ready_i      (sready[0]),
        .sat_o            (sat[0]),
        .zero_o           (zero[0]),
        .elem_cnt_o       (cnt[0])
    );

    softmax_sum_acc #(.N_ELEM(16), .DATA_W(32), .CNT_W(5)) u_dut16 (
        .clock_i          (clk),
        .reset_n_i        (rst_n),
        .add_data_i       (adata[1]),
        .add_data_valid_i (avld[1]),
        .add_ready_o      (aready[1]),
        .sum_data_o       (sdata[1]),
        .sum_data_valid_o (svalid[1]),
        .sum_ready_i      (sready[1]),
        .sat_o            (sat[1]),
        .zero_o           (zero[1]),
        .elem_cnt_o       (cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every transfer against the head of the scoreboard
    task automatic mon(input int idx);
        exp_t e;
        int   sz;
        sz = (idx == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_sum inst%0d: got %h expected no transfer", idx, sdata[idx]);
        end else begin
            if (idx == 0) e = q0.pop_front();
            else          e = q1.pop_front();
            chk($sformatf("mon_sum inst%0d", idx),  sdata[idx],       e.sum);
            chk($sformatf("mon_sat inst%0d", idx),  32'(sat[idx]),    32'(e.sat));
            chk($sformatf("mon_zero inst%0d", idx), 32'(zero[idx]),   32'(e.zero));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (svalid[0] && sready[0]) mon(0);
            if (svalid[1] && sready[1]) mon(1);
        end
    end

    // Inputs change 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [31:0] s, input logic st, input logic z);
        exp_t e;
        e.sum  = s;
        e.sat  = st;
        e.zero = z;
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // Issue n elements of value d; optional one-cycle gap between elements
    task automatic send_vec(input int idx, input logic [31:0] d, input int n,
                            input bit gap, input bit chk_cnt);
        for (int k = 0; k < n; k++) begin
            avld[idx]  = 1'b1;
            adata[idx] = d;
            if (k == n - 1) chk("valid_early", 32'(svalid[idx]), 32'd0);
            cyc();
            if (chk_cnt) chk("cnt_accept", 32'(cnt[idx]), 32'(k + 1));
            if (gap && k < n - 1) begin
                avld[idx] = 1'b0;
                cyc();
                if (chk_cnt) chk("cnt_gap", 32'(cnt[idx]), 32'(k + 1));
            end
        end
        avld[idx] = 1'b0;
    endtask

    task automatic chk_reset(input int idx);
        chk($sformatf("rst_ready inst%0d", idx), 32'(aready[idx]), 32'd1);
        chk($sformatf("rst_valid inst%0d", idx), 32'(svalid[idx]), 32'd0);
        chk($sformatf("rst_sum inst%0d", idx),   sdata[idx],        32'd0);
        chk($sformatf("rst_cnt inst%0d", idx),   32'(cnt[idx]),    32'd0);
        chk($sformatf("rst_sat inst%0d", idx),   32'(sat[idx]),    32'd0);
        chk($sformatf("rst_zero inst%0d", idx),  32'(zero[idx]),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            adata[i]  = '0;
            avld[i]   = 1'b0;
            sready[i] = 1'b0;
        end
        cyc();
        cyc();
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        cyc();

        // Basic sum: 10 x 1.0 -> 10.0
        sready[0] = 1'b1;
        push_exp(0, 32'hA000_0000, 1'b0, 1'b0);
        send_vec(0, 32'h1000_0000, 10, 1'b0, 1'b0);
        chk("basic_valid", 32'(svalid[0]), 32'd1);
        chk("basic_cnt",   32'(cnt[0]),    32'd10);
        chk("basic_ready", 32'(aready[0]), 32'd0);
        cyc();
        chk("basic_drop",  32'(svalid[0]), 32'd0);
        chk("basic_cnt0",  32'(cnt[0]),    32'd0);
        chk("basic_rdy1",  32'(aready[0]), 32'd1);
        chk("basic_hold",  sdata[0],       32'hA000_0000);

        // Gapped input: 10 x 0.5 -> 5.0
        push_exp(0, 32'h5000_0000, 1'b0, 1'b0);
        send_vec(0, 32'h0800_0000, 10, 1'b1, 1'b1);
        cyc();

        // Backpressure: hold output 5 cycles, extra inputs ignored
        sready[0] = 1'b0;
        push_exp(0, 32'h1400_0000, 1'b0, 1'b0);
        send_vec(0, 32'h0200_0000, 10, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            avld[0]  = 1'b1;
            adata[0] = 32'h1000_0000;
            cyc();
            chk("bp_sum",   sdata[0],        32'h1400_0000);
            chk("bp_valid", 32'(svalid[0]),  32'd1);
            chk("bp_ready", 32'(aready[0]),  32'd0);
            chk("bp_sat",   32'(sat[0]),     32'd0);
            chk("bp_zero",  32'(zero[0]),    32'd0);
            chk("bp_cnt",   32'(cnt[0]),     32'd10);
        end
        avld[0]   = 1'b0;
        sready[0] = 1'b1;
        cyc();
        chk("bp_cnt0", 32'(cnt[0]), 32'd0);
        push_exp(0, 32'h5000_0000, 1'b0, 1'b0);
        send_vec(0, 32'h0800_0000, 10, 1'b0, 1'b0);
        cyc();

        // Saturation on the 16-element instance
        sready[1] = 1'b1;
        push_exp(1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_vec(1, 32'h1000_0000, 16, 1'b0, 1'b0);
        chk("sat_set",   32'(sat[1]),    32'd1);
        chk("sat_valid", 32'(svalid[1]), 32'd1);
        cyc();
        chk("sat_clr",   32'(sat[1]),    32'd0);
        push_exp(1, 32'h1000_0000, 1'b0, 1'b0);
        send_vec(1, 32'h0100_0000, 16, 1'b0, 1'b0);
        cyc();

        // Zero guard
        push_exp(0, 32'h0000_0001, 1'b0, 1'b1);
        send_vec(0, 32'h0000_0000, 10, 1'b0, 1'b0);
        chk("zero_flag", 32'(zero[0]), 32'd1);
        chk("zero_sum",  sdata[0],     32'h0000_0001);
        cyc();

        // Reset mid-vector discards the partial sum
        send_vec(0, 32'h1000_0000, 4, 1'b0, 1'b0);
        chk("pre_rst_cnt", 32'(cnt[0]), 32'd4);
        rst_n = 1'b0;
        cyc();
        chk_reset(0);
        rst_n = 1'b1;
        push_exp(0, 32'h0A00_0000, 1'b0, 1'b0);
        send_vec(0, 32'h0100_0000, 10, 1'b0, 1'b0);
        cyc();

        cyc();
        cyc();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
